// File: rtl/aes_pkg.sv
// Shared AES definitions for the MixColumns engine.
//   GF_POLY      : AES reduction polynomial low byte (x^8 + x^4 + x^3 + x + 1)
//   state_t      : 128-bit AES state; column c = bits [32c:32c+31], row 0 first
//   col_t        : 32-bit column; row 0 byte in [31:24]
//   fsm_state_t  : engine FSM states
package aes_pkg;

  localparam int unsigned STATE_W = 128;
  localparam int unsigned COL_W   = 32;
  localparam int unsigned BYTE_W  = 8;

  localparam logic [BYTE_W-1:0] GF_POLY = 8'h1b;

  typedef logic [0:STATE_W-1] state_t;
  typedef logic [COL_W-1:0]   col_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } fsm_state_t;

  // Multiply by 02 in GF(2^8).
  function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] b);
    return {b[BYTE_W-2:0], 1'b0} ^ (b[BYTE_W-1] ? GF_POLY : 8'h00);
  endfunction

  // Multiply by 03 in GF(2^8).
  function automatic logic [BYTE_W-1:0] mul3(input logic [BYTE_W-1:0] b);
    return xtime(b) ^ b;
  endfunction

endpackage

// File: rtl/mix_column_word.sv
// Combinational MixColumns of a single 32-bit column.
//   col_i : input column, row 0 byte in [31:24]
//   col_o : mixed column, same layout
module mix_column_word
  import aes_pkg::*;
(
  input  col_t col_i,
  output col_t col_o
);

  logic [BYTE_W-1:0] b0, b1, b2, b3;

  assign {b0, b1, b2, b3} = col_i;

  // Rows {02 03 01 01}, {01 02 03 01}, {01 01 02 03}, {03 01 01 02}.
  assign col_o = {xtime(b0) ^ mul3(b1)  ^ b2        ^ b3,
                  b0        ^ xtime(b1) ^ mul3(b2)  ^ b3,
                  b0        ^ b1        ^ xtime(b2) ^ mul3(b3),
                  mul3(b0)  ^ b1        ^ b2        ^ xtime(b3)};

endmodule

// File: rtl/mix_columns_engine.sv
// Iterative AES MixColumns engine: accepts a state, mixes LANES columns per
// BUSY cycle in place, then holds the result until downstream takes it.
//   clk, rst            : clock, async active-high reset
//   in_valid/in_ready   : input handshake (ready only in IDLE)
//   in_state, in_bypass : state to mix; bypass passes it through unmixed
//   out_valid/out_ready : output handshake (valid only in DONE)
//   out_state           : internal state register, qualified by out_valid
module mix_columns_engine
  import aes_pkg::*;
#(
  parameter int unsigned LANES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [0:127]     in_state,
  input  logic             in_bypass,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [0:127]     out_state
);

  localparam int unsigned CNT_W = 2;
  localparam logic [CNT_W-1:0] STEP = CNT_W'(LANES);
  localparam logic [CNT_W-1:0] LAST_OFS = CNT_W'(LANES - 1);

  if (LANES != 1 && LANES != 2 && LANES != 4) begin : g_lanes_chk
    $error("mix_columns_engine: LANES must be 1, 2 or 4");
  end

  fsm_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  state_t           st_q, st_d;
  logic             byp_q, byp_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [CNT_W-1:0] lane_idx [LANES];
  col_t             lane_out [LANES];
  logic [CNT_W-1:0] last_col;

  // One mixer per lane, fed from columns cnt..cnt+LANES-1.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_idx[l] = CNT_W'(cnt_q + CNT_W'(l));
    mix_column_word u_mix (
      .col_i (st_q[{lane_idx[l], 5'd0} +: COL_W]),
      .col_o (lane_out[l])
    );
  end

  assign last_col = CNT_W'(cnt_q + LAST_OFS);

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    st_d    = st_q;
    byp_d   = byp_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          st_d    = in_state;
          byp_d   = in_bypass;
          cnt_d   = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        // Bypass keeps the same cycle count but leaves columns untouched.
        if (!byp_q) begin
          for (int unsigned l = 0; l < LANES; l++) begin
            st_d[{lane_idx[l], 5'd0} +: COL_W] = lane_out[l];
          end
        end
        cnt_d = CNT_W'(cnt_q + STEP);
        if (last_col == 2'd3) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      st_q        <= '0;
      byp_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      st_q        <= st_d;
      byp_q       <= byp_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_state = st_q;

endmodule

// File: tb/tb_mix_columns_engine.sv
// Self-checking bench: three engines (LANES = 1, 2, 4) against a GF(2^8)
// matrix-multiply reference model.
module tb_mix_columns_engine;
  import aes_pkg::*;

  localparam int unsigned NDUT = 3;

  logic   clk = 1'b0;
  logic   rst_a       [NDUT];
  logic   in_valid_a  [NDUT];
  logic   in_ready_a  [NDUT];
  state_t in_state_a  [NDUT];
  logic   in_bypass_a [NDUT];
  logic   out_valid_a [NDUT];
  logic   out_ready_a [NDUT];
  state_t out_state_a [NDUT];

  int errors = 0;
  int checks = 0;

  localparam state_t FIPS_IN  = 128'hf20a225c_c6c6c6c6_d4d4d4d5_2d26314c;
  localparam state_t FIPS_OUT = 128'h9fdc589d_c6c6c6c6_d5d5d7d6_4d7ebdf8;
  localparam state_t V29_IN   = 128'hdb135345_01010101_01010101_01010101;
  localparam state_t V29_OUT  = 128'h8e4da1bc_01010101_01010101_01010101;
  localparam state_t ALL01    = {16{8'h01}};

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    mix_columns_engine #(.LANES(1 << g)) u_dut (
      .clk       (clk),
      .rst       (rst_a[g]),
      .in_valid  (in_valid_a[g]),
      .in_ready  (in_ready_a[g]),
      .in_state  (in_state_a[g]),
      .in_bypass (in_bypass_a[g]),
      .out_valid (out_valid_a[g]),
      .out_ready (out_ready_a[g]),
      .out_state (out_state_a[g])
    );
  end

  // Generic GF(2^8) product by repeated doubling.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p ^= aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // Reference: state-wide matrix product, or identity when bypassed.
  function automatic state_t ref_mix(input state_t s, input logic byp);
    int unsigned m [4][4] = '{'{2, 3, 1, 1}, '{1, 2, 3, 1}, '{1, 1, 2, 3}, '{3, 1, 1, 2}};
    state_t r;
    logic [7:0] b [4];
    logic [7:0] acc;
    r = s;
    if (!byp) begin
      for (int c = 0; c < 4; c++) begin
        for (int k = 0; k < 4; k++) b[k] = s[32*c + 8*k +: 8];
        for (int row = 0; row < 4; row++) begin
          acc = 8'h00;
          for (int k = 0; k < 4; k++) acc ^= gmul(8'(m[row][k]), b[k]);
          r[32*c + 8*row +: 8] = acc;
        end
      end
    end
    return r;
  endfunction

  function automatic state_t rand_state();
    state_t s;
    for (int i = 0; i < 4; i++) s[32*i +: 32] = $urandom;
    return s;
  endfunction

  // Drive one block; return at the negedge where out_valid is first seen.
  task automatic send(input int d, input state_t st, input logic byp,
                      output int lat, output bit ok);
    int guard;
    guard = 0; lat = 0; ok = 1'b0;
    @(negedge clk);
    while (!in_ready_a[d] && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready_a[d]) return;
    in_valid_a[d]  = 1'b1;
    in_state_a[d]  = st;
    in_bypass_a[d] = byp;
    @(negedge clk);
    in_valid_a[d]  = 1'b0;
    in_bypass_a[d] = 1'b0;
    in_state_a[d]  = rand_state();
    while (!out_valid_a[d] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    ok = out_valid_a[d];
  endtask

  task automatic release_out(input int d);
    out_ready_a[d] = 1'b1;
    @(negedge clk);
    out_ready_a[d] = 1'b0;
  endtask

  task automatic test_reset();
    for (int d = 0; d < NDUT; d++) begin
      checks++;
      if (in_ready_a[d] !== 1'b1 || out_valid_a[d] !== 1'b0 || out_state_a[d] !== '0) begin
        errors++;
        $display("FAIL reset_state dut%0d: in_ready=%b out_valid=%b out_state=%h, required 1 0 0",
                 d, in_ready_a[d], out_valid_a[d], out_state_a[d]);
      end
    end
  endtask

  task automatic test_single_column();
    int lat; bit ok;
    send(0, V29_IN, 1'b0, lat, ok);
    checks++;
    if (!ok || out_state_a[0] !== V29_OUT || out_state_a[0] !== ref_mix(V29_IN, 1'b0) || lat != 4) begin
      errors++;
      $display("FAIL single_column: valid=%b state=%h lat=%0d, required state=%h lat=4",
               ok, out_state_a[0], lat, V29_OUT);
    end
    release_out(0);
  endtask

  task automatic test_fips(input logic byp);
    int lat; bit ok;
    state_t exp;
    exp = byp ? FIPS_IN : FIPS_OUT;
    for (int d = 0; d < NDUT; d++) begin
      send(d, FIPS_IN, byp, lat, ok);
      checks++;
      if (!ok || out_state_a[d] !== exp || lat != (4 >> d)) begin
        errors++;
        $display("FAIL fips byp=%b dut%0d: valid=%b state=%h lat=%0d, required state=%h lat=%0d",
                 byp, d, ok, out_state_a[d], lat, exp, 4 >> d);
      end
      checks++;
      if (in_ready_a[d] !== 1'b0) begin
        errors++;
        $display("FAIL ready_in_done dut%0d: in_ready=%b, required 0", d, in_ready_a[d]);
      end
      release_out(d);
      checks++;
      if (in_ready_a[d] !== 1'b1 || out_valid_a[d] !== 1'b0) begin
        errors++;
        $display("FAIL handoff dut%0d: in_ready=%b out_valid=%b, required 1 0",
                 d, in_ready_a[d], out_valid_a[d]);
      end
    end
  endtask

  task automatic test_stall();
    int lat; bit ok;
    send(0, FIPS_IN, 1'b0, lat, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL stall_setup: out_valid=%b, required 1", ok);
    end
    for (int i = 0; i < 10; i++) begin
      in_valid_a[0] = 1'b1;
      in_state_a[0] = rand_state();
      @(negedge clk);
      checks++;
      if (out_valid_a[0] !== 1'b1 || out_state_a[0] !== FIPS_OUT || in_ready_a[0] !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold cyc%0d: valid=%b ready=%b state=%h, required 1 0 %h",
                 i, out_valid_a[0], in_ready_a[0], out_state_a[0], FIPS_OUT);
      end
    end
    // in_valid stays high across the handoff edge: no same-cycle accept.
    release_out(0);
    checks++;
    if (in_ready_a[0] !== 1'b1 || out_valid_a[0] !== 1'b0) begin
      errors++;
      $display("FAIL stall_release: in_ready=%b out_valid=%b, required 1 0",
               in_ready_a[0], out_valid_a[0]);
    end
    in_valid_a[0] = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (in_ready_a[0] !== 1'b1 || out_valid_a[0] !== 1'b0) begin
      errors++;
      $display("FAIL stall_no_ghost: in_ready=%b out_valid=%b, required 1 0",
               in_ready_a[0], out_valid_a[0]);
    end
  endtask

  task automatic test_reset_mid_busy();
    int lat; bit ok;
    @(negedge clk);
    in_valid_a[0] = 1'b1;
    in_state_a[0] = FIPS_IN;
    @(negedge clk);
    in_valid_a[0] = 1'b0;
    @(negedge clk);
    rst_a[0] = 1'b1;
    #1;
    checks++;
    if (out_valid_a[0] !== 1'b0 || in_ready_a[0] !== 1'b1 || out_state_a[0] !== '0) begin
      errors++;
      $display("FAIL mid_busy_reset: out_valid=%b in_ready=%b state=%h, required 0 1 0",
               out_valid_a[0], in_ready_a[0], out_state_a[0]);
    end
    @(negedge clk);
    rst_a[0] = 1'b0;
    send(0, ALL01, 1'b0, lat, ok);
    checks++;
    if (!ok || out_state_a[0] !== ALL01 || lat != 4) begin
      errors++;
      $display("FAIL after_reset_block: valid=%b state=%h lat=%0d, required %h lat=4",
               ok, out_state_a[0], lat, ALL01);
    end
    release_out(0);
  endtask

  task automatic test_back_to_back(input int d, input int n);
    state_t exp_q [$];
    state_t exp, s;
    int acc, done, cyc;
    acc = 0; done = 0; cyc = 0;
    while (done < n && cyc < 40 * n) begin
      @(negedge clk);
      cyc++;
      out_ready_a[d] = ($urandom_range(0, 1) == 1);
      if (out_valid_a[d] && out_ready_a[d]) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL b2b dut%0d: unexpected output %h", d, out_state_a[d]);
        end else begin
          exp = exp_q.pop_front();
          if (out_state_a[d] !== exp) begin
            errors++;
            $display("FAIL b2b dut%0d blk%0d: got %h, required %h", d, done, out_state_a[d], exp);
          end
        end
        done++;
      end
      if (acc < n) begin
        s = rand_state();
        in_valid_a[d]  = ($urandom_range(0, 3) != 0);
        in_state_a[d]  = s;
        in_bypass_a[d] = ($urandom_range(0, 7) == 0);
        if (in_valid_a[d] && in_ready_a[d]) begin
          exp_q.push_back(ref_mix(s, in_bypass_a[d]));
          acc++;
        end
      end else begin
        in_valid_a[d] = 1'b0;
      end
    end
    @(negedge clk);
    in_valid_a[d]  = 1'b0;
    in_bypass_a[d] = 1'b0;
    out_ready_a[d] = 1'b0;
    checks++;
    if (done != n || acc != n || exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_count dut%0d: accepted=%0d delivered=%0d pending=%0d, required %0d %0d 0",
               d, acc, done, exp_q.size(), n, n);
    end
  endtask

  initial begin
    for (int d = 0; d < NDUT; d++) begin
      rst_a[d] = 1'b1; in_valid_a[d] = 1'b0; in_state_a[d] = '0;
      in_bypass_a[d] = 1'b0; out_ready_a[d] = 1'b0;
    end
    repeat (2) @(negedge clk);
    test_reset();
    for (int d = 0; d < NDUT; d++) rst_a[d] = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_column();
    test_fips(1'b0);
    test_fips(1'b1);
    test_stall();
    test_reset_mid_busy();
    test_back_to_back(0, 1000);
    test_back_to_back(1, 200);
    test_back_to_back(2, 200);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog");
  end

endmodule
